load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: WORD_ADDR, default 1, meaning 1 = mem_addr carries word index {2'b00, addr[31:2]}; 0 = byte address with addr[1:0] forced to 00.
REQ-002 clk  input  1  rising-edge clock shared with data_memory.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  1  request from the execute stage is present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_store  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 req_signed  input  1  loads only; 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and traps.
REQ-013 resp_trap  output  1  mem_address_not_aligned, valid with resp_valid.
REQ-014 mem_addr  output  32  address to data_memory.
REQ-015 mem_write_data  output  32  full-word write data to data_memory.
REQ-016 mem_memwrite  output  1  write enable to data_memory.
REQ-017 mem_read_data  input  32  combinational read data from data_memory for mem_addr.

Function
REQ-018 FSM states: IDLE, ACCESS, WRITE, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid & req_ready.
REQ-020 On acceptance, all req_* fields SHALL be latched; later changes to req_* have no effect until the next acceptance.
REQ-021 Misalignment: size 11, halfword with addr[0]=1, or word with addr[1:0]!=00; next state RESP with resp_trap=1 and no memory access.
REQ-022 Aligned request: IDLE -> ACCESS; mem_addr SHALL be driven from the latched address in ACCESS and WRITE.
REQ-023 Load: ACCESS -> RESP; resp_rdata registered at the ACCESS->RESP edge from mem_read_data.
REQ-024 Byte lanes are big-endian: byte offset 0 = bits[31:24], offset 3 = bits[7:0]; halfword offset 0 = bits[31:16], offset 2 = bits[15:0].
REQ-025 Extension: selected lane extended to 32 bits, sign-extended iff req_signed, zero-extended otherwise.
REQ-026 Word store: mem_memwrite=1 during ACCESS only, mem_write_data = latched wdata; ACCESS -> RESP.
REQ-027 Byte/halfword store: ACCESS reads the word; merged word (wdata[7:0] or wdata[15:0] into the addressed lane, other lanes from mem_read_data) registered at ACCESS->WRITE edge; mem_memwrite=1 during WRITE only; WRITE -> RESP.
REQ-028 RESP: resp_valid=1 for exactly one cycle, then IDLE; resp_rdata and resp_trap hold their values until the next RESP.
REQ-029 Latency, counted from the acceptance edge: trap response 1 cycle, load 2, word store 2, sub-word store 3.
REQ-030 mem_memwrite SHALL be 0 in IDLE and RESP and SHALL be asserted at most once per request.
REQ-031 mem_memwrite SHALL be gated by ~reset so no write occurs on an edge where reset is high.

Reset
REQ-032 reset high at a rising edge: state=IDLE, resp_valid=0, resp_trap=0, resp_rdata=0, merge register=0, latched request cleared.
REQ-033 Reset in any state SHALL abort the in-flight request with no response and no memory write; req_ready=1 in the cycle after reset deasserts.
REQ-034 mem_addr and mem_write_data SHALL be 0 after reset until the next acceptance.

Verification
REQ-035 Word store 0x00000007 to 0x4, then word load 0x4 -> mem_memwrite high exactly 1 cycle with mem_addr=1; load resp_rdata=0x00000007 at accept+2; resp_trap=0.
REQ-036 Memory word 1 = 0x11223344; byte store wdata 0x000000AB to 0x5 -> memory word 1 = 0x11AB3344; resp_valid at accept+3; a single memwrite cycle, in WRITE.
REQ-037 Loads from word 0x11AB3344: signed byte 0x5 -> 0xFFFFFFAB; unsigned byte 0x5 -> 0x000000AB; signed half 0x6 -> 0x00003344; signed half 0x4 -> 0x000011AB.
REQ-038 Word load 0x6 and half load 0x3 -> resp_trap=1, resp_rdata=0 at accept+1; mem_memwrite never asserted.
REQ-039 Reset asserted during WRITE of a byte store -> no write, memory word unchanged, no resp_valid, req_ready=1 the cycle after reset drops.
REQ-040 req_valid held high across 3 back-to-back requests -> each is accepted only in IDLE; responses arrive in order; req_ready=0 throughout ACCESS/WRITE/RESP.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: aligned byte/half/word accesses to a word-wide data_memory, big-endian lanes.
// Latency from acceptance edge: trap 1, load 2, word store 2, sub-word store (read-merge-write) 3.
// Backpressure: req_ready is high only in IDLE, so one request is in flight at a time.
module load_store_unit #(
  parameter int unsigned WORD_ADDR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_trap,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        trap_q, trap_d;

  logic        req_misaligned;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic [31:0] merged_word;

  // Alignment of the incoming request; reserved size always traps.
  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      SZ_BYTE: req_misaligned = 1'b0;
      SZ_HALF: req_misaligned = req_addr[0];
      SZ_WORD: req_misaligned = (req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b1;
    endcase
  end

  // Lane selection and extension of read data; offset 0 is the most significant byte.
  always_comb begin
    byte_lane = 8'h00;
    case (addr_q[1:0])
      2'd0:    byte_lane = mem_read_data[31:24];
      2'd1:    byte_lane = mem_read_data[23:16];
      2'd2:    byte_lane = mem_read_data[15:8];
      default: byte_lane = mem_read_data[7:0];
    endcase
    half_lane = addr_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];
    case (size_q)
      SZ_BYTE: load_ext = {{24{signed_q & byte_lane[7]}}, byte_lane};
      SZ_HALF: load_ext = {{16{signed_q & half_lane[15]}}, half_lane};
      default: load_ext = mem_read_data;
    endcase
  end

  // Insert the store lane into the word currently held in memory.
  always_comb begin
    merged_word = mem_read_data;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merged_word = {wdata_q[7:0], mem_read_data[23:0]};
        2'd1:    merged_word = {mem_read_data[31:24], wdata_q[7:0], mem_read_data[15:0]};
        2'd2:    merged_word = {mem_read_data[31:16], wdata_q[7:0], mem_read_data[7:0]};
        default: merged_word = {mem_read_data[31:8], wdata_q[7:0]};
      endcase
    end else begin
      merged_word = addr_q[1] ? {mem_read_data[31:16], wdata_q[15:0]}
                              : {wdata_q[15:0], mem_read_data[15:0]};
    end
  end

  // Next-state logic; response registers only change on entry to RESP so they hold between responses.
  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    trap_d   = trap_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (req_misaligned) begin
            state_d = RESP;
            trap_d  = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!store_q) begin
          rdata_d = load_ext;
          trap_d  = 1'b0;
          state_d = RESP;
        end else if (size_q == SZ_WORD) begin
          rdata_d = 32'h0;
          trap_d  = 1'b0;
          state_d = RESP;
        end else begin
          merge_d = merged_word;
          state_d = WRITE;
        end
      end
      WRITE: begin
        rdata_d = 32'h0;
        trap_d  = 1'b0;
        state_d = RESP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      merge_q  <= 32'h0;
      rdata_q  <= 32'h0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      trap_q   <= trap_d;
    end
  end

  // Memory-side and handshake outputs; the write strobe is masked by reset so an abort never writes.
  always_comb begin
    req_ready      = (state_q == IDLE);
    resp_valid     = (state_q == RESP);
    resp_rdata     = rdata_q;
    resp_trap      = trap_q;
    mem_addr       = (WORD_ADDR != 0) ? {2'b00, addr_q[31:2]} : {addr_q[31:2], 2'b00};
    mem_write_data = (state_q == WRITE) ? merge_q : wdata_q;
    mem_memwrite   = ~reset & (((state_q == ACCESS) & store_q & (size_q == SZ_WORD)) |
                               (state_q == WRITE));
  end

endmodule
